// File: rtl/spi_debug_hub.sv
// Multi-channel SPI mode-0 debug slave: NB_CH chip selects share one SCLK/MOSI/MISO bus.
// SPI pins are resynchronised into i_clk and acted on through edge detection.
`timescale 1ns/1ps
module spi_debug_hub #(
   parameter int NB_BITS   = 32,
   parameter int NB_CH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_SCLK,
   input  logic                     i_MOSI,
   input  logic [NB_CH-1:0]         i_SPI_cs,
   input  logic [NB_CH*NB_BITS-1:0] i_data,
   output logic                     o_MISO,
   output logic [NB_CH*NB_BITS-1:0] o_data,
   output logic [NB_CH-1:0]         o_valid,
   output logic                     o_cs_err
);
   localparam int CNT_W = $clog2(NB_BITS + 1);
   localparam int CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE, ERR} state_e;

   state_e                   state_q, state_d;
   logic [2:0]               sclk_q, sclk_d;   // [0] meta, [1] sync, [2] history
   logic [1:0]               mosi_q, mosi_d;
   logic [NB_CH-1:0]         cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d;
   logic [CH_W-1:0]          ch_q, ch_d;
   logic [NB_BITS-1:0]       sr_q, sr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     miso_q, miso_d;
   logic [NB_CH*NB_BITS-1:0] data_q, data_d;
   logic [NB_CH-1:0]         valid_q, valid_d;
   logic                     err_q, err_d;
   logic                     armed_q, armed_d;
   logic                     settle_q, settle_d;

   logic [NB_CH-1:0]   cs_low;
   logic               one_low, multi_low, sclk_rise, sclk_fall;
   logic [CH_W-1:0]    low_idx;
   logic [NB_BITS-1:0] word_sel, sr_shift;
   logic [CNT_W-1:0]   cnt_inc;

   always_comb begin
      sclk_d    = {sclk_q[1:0], i_SCLK};
      mosi_d    = {mosi_q[0], i_MOSI};
      cs_meta_d = i_SPI_cs;
      cs_sync_d = cs_meta_q;

      cs_low    = ~cs_sync_q;
      multi_low = |(cs_low & (cs_low - NB_CH'(1)));
      one_low   = |cs_low && !multi_low;
      low_idx   = '0;
      for (int k = 0; k < NB_CH; k++) begin
         if (cs_low[k]) low_idx = CH_W'(k);
      end
      sclk_rise = sclk_q[1] & ~sclk_q[2];
      sclk_fall = ~sclk_q[1] & sclk_q[2];
      word_sel  = i_data[int'(ch_q)*NB_BITS +: NB_BITS];
      sr_shift  = MSB_FIRST ? {sr_q[NB_BITS-2:0], mosi_q[1]} : {mosi_q[1], sr_q[NB_BITS-1:1]};
      cnt_inc   = cnt_q + CNT_W'(1);
   end

   always_comb begin
      // NOTE: every next-state variable gets a default first so no path can infer a latch.
      state_d  = state_q;
      ch_d     = ch_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      miso_d   = miso_q;
      data_d   = data_q;
      valid_d  = '0;
      err_d    = err_q;
      settle_d = 1'b1;
      // A completed frame disarms until every cs has been seen high; after reset the
      // cs synchronisers need one cycle (settle) before they reflect the real pins.
      armed_d  = (armed_q && state_q != DONE) || (settle_q && &cs_meta_q && &cs_sync_q);

      case (state_q)
         IDLE: begin
            if (armed_q && one_low) begin
               state_d = LOAD;
               ch_d    = low_idx;
            end
         end
         LOAD: begin
            state_d = SHIFT;
            sr_d    = word_sel;
            cnt_d   = '0;
            miso_d  = MSB_FIRST ? word_sel[NB_BITS-1] : word_sel[0];
         end
         SHIFT: begin
            if (sclk_rise) begin
               sr_d  = sr_shift;
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(NB_BITS)) begin
                  state_d                                  = DONE;
                  data_d[int'(ch_q)*NB_BITS +: NB_BITS] = sr_shift;
                  valid_d[ch_q]                            = 1'b1;
               end
            end else if (sclk_fall) begin
               miso_d = MSB_FIRST ? sr_q[NB_BITS-1] : sr_q[0];
            end
            // Completion wins over a cs release detected in the same cycle.
            if (state_d != DONE && cs_sync_q[ch_q]) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     if (&cs_sync_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (multi_low) begin
         state_d = ERR;
         err_d   = 1'b1;
         data_d  = data_q;
         valid_d = '0;
         cnt_d   = '0;
      end
      if (state_d == IDLE || state_d == ERR) miso_d = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         sclk_q    <= '0;
         mosi_q    <= '0;
         // NOTE: cs synchronisers reset to 1 so reset itself never looks like a cs assertion.
         cs_meta_q <= '1;
         cs_sync_q <= '1;
         ch_q      <= '0;
         sr_q      <= '0;
         cnt_q     <= '0;
         miso_q    <= 1'b0;
         data_q    <= '0;
         valid_q   <= '0;
         err_q     <= 1'b0;
         armed_q   <= 1'b0;
         settle_q  <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignment so all flops update together.
         state_q   <= state_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         cs_meta_q <= cs_meta_d;
         cs_sync_q <= cs_sync_d;
         ch_q      <= ch_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         miso_q    <= miso_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         armed_q   <= armed_d;
         settle_q  <= settle_d;
      end
   end

   assign o_MISO   = miso_q;
   assign o_data   = data_q;
   assign o_valid  = valid_q;
   assign o_cs_err = err_q;

endmodule

// File: tb/tb_spi_debug_hub.sv
// Self-checking bench for spi_debug_hub: a 32-bit/4-channel MSB-first hub and an
// 8-bit/2-channel LSB-first hub driven by a bit-banged SPI master at SCLK = clk/8.
`timescale 1ns/1ps
module tb_spi_debug_hub;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         a_sclk, a_mosi, a_miso, a_err;
   logic [3:0]   a_cs, a_valid;
   logic [127:0] a_data, a_odata;
   logic         b_sclk, b_mosi, b_miso, b_err;
   logic [1:0]   b_cs, b_valid;
   logic [15:0]  b_data, b_odata;

   spi_debug_hub #(.NB_BITS(32), .NB_CH(4), .MSB_FIRST(1'b1)) u_a (
      .i_clk(clk), .i_rst(rst), .i_SCLK(a_sclk), .i_MOSI(a_mosi), .i_SPI_cs(a_cs),
      .i_data(a_data), .o_MISO(a_miso), .o_data(a_odata), .o_valid(a_valid), .o_cs_err(a_err));

   spi_debug_hub #(.NB_BITS(8), .NB_CH(2), .MSB_FIRST(1'b0)) u_b (
      .i_clk(clk), .i_rst(rst), .i_SCLK(b_sclk), .i_MOSI(b_mosi), .i_SPI_cs(b_cs),
      .i_data(b_data), .o_MISO(b_miso), .o_data(b_odata), .o_valid(b_valid), .o_cs_err(b_err));

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_a [4];
   logic [7:0]  exp_b [2];

   // Valid-pulse monitor: counts cycles with any valid high and snapshots data at the pulse.
   int           a_vcnt = 0, b_vcnt = 0;
   logic [3:0]   a_vlast = '0;
   logic [1:0]   b_vlast = '0;
   logic [127:0] a_vdata = '0;
   logic [15:0]  b_vdata = '0;
   always @(negedge clk) begin
      if (a_valid != '0) begin a_vcnt++; a_vlast = a_valid; a_vdata = a_odata; end
      if (b_valid != '0) begin b_vcnt++; b_vlast = b_valid; b_vdata = b_odata; end
   end

   function automatic logic [127:0] exp_a_vec();
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[k*32 +: 32] = exp_a[k];
      return v;
   endfunction

   // Master clocks n bits MSB-first, sampling MISO mid high phase.
   task automatic a_bits(input logic [31:0] mosi_w, input int n, input bit rel_last,
                         input int ch, output logic [31:0] miso_w);
      miso_w = '0;
      for (int i = 0; i < n; i++) begin
         a_mosi = mosi_w[31-i];
         repeat (4) @(negedge clk);
         a_sclk = 1'b1;
         if (rel_last && i == n - 1) a_cs[ch] = 1'b1;
         repeat (2) @(negedge clk);
         miso_w[31-i] = a_miso;
         repeat (2) @(negedge clk);
         a_sclk = 1'b0;
      end
   endtask

   task automatic a_frame(input int ch, input logic [31:0] txw, input logic [31:0] rxw,
                          input int nbits, input bit rel_last, input int extra,
                          output logic [31:0] misow);
      logic [31:0] junk;
      a_data[ch*32 +: 32] = txw;
      a_cs[ch] = 1'b0;
      repeat (6) @(negedge clk);
      a_data[ch*32 +: 32] = $urandom();   // must not disturb the frame in flight
      repeat (2) @(negedge clk);
      a_bits(rxw, nbits, rel_last, ch, misow);
      if (extra > 0) a_bits($urandom(), extra, 1'b0, ch, junk);
      repeat (4) @(negedge clk);
      a_cs[ch] = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic b_frame(input int ch, input logic [7:0] txw, input logic [7:0] rxw,
                          output logic [7:0] misow);
      b_data[ch*8 +: 8] = txw;
      b_cs[ch] = 1'b0;
      repeat (8) @(negedge clk);
      misow = '0;
      for (int i = 0; i < 8; i++) begin
         b_mosi = rxw[i];
         repeat (4) @(negedge clk);
         b_sclk = 1'b1;
         repeat (2) @(negedge clk);
         misow[i] = b_miso;
         repeat (2) @(negedge clk);
         b_sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      b_cs[ch] = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (a_odata !== '0 || a_valid !== '0 || a_miso !== 1'b0 || a_err !== 1'b0) begin
         n_errors++; $display("FAIL reset_a: data=%h valid=%b miso=%b err=%b, want all 0", a_odata, a_valid, a_miso, a_err); end
      n_checks++; if (b_odata !== '0 || b_valid !== '0 || b_miso !== 1'b0 || b_err !== 1'b0) begin
         n_errors++; $display("FAIL reset_b: data=%h valid=%b miso=%b err=%b, want all 0", b_odata, b_valid, b_miso, b_err); end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) exp_a[k] = '0;
      for (int k = 0; k < 2; k++) exp_b[k] = '0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single();
      logic [31:0] m;
      int v0 = a_vcnt;
      a_frame(0, 32'hDEADBEEF, 32'h12345678, 32, 1'b0, 4, m);
      exp_a[0] = 32'h12345678;
      n_checks++; if (m !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_miso: got %h want %h", m, 32'hDEADBEEF); end
      n_checks++; if (a_vcnt - v0 !== 1 || a_vlast !== 4'b0001) begin
         n_errors++; $display("FAIL single_valid: pulses=%0d last=%b want 1 pulse 0001", a_vcnt - v0, a_vlast); end
      n_checks++; if (a_vdata !== exp_a_vec()) begin n_errors++; $display("FAIL single_data_at_valid: got %h want %h", a_vdata, exp_a_vec()); end
      n_checks++; if (a_odata !== exp_a_vec()) begin n_errors++; $display("FAIL single_data: got %h want %h", a_odata, exp_a_vec()); end
   endtask

   task automatic test_sweep();
      logic [31:0] m, tx;
      for (int ch = 1; ch < 4; ch++) begin
         int v0 = a_vcnt;
         tx = $urandom();
         a_frame(ch, tx, 32'hA5A5_0000 | 32'(ch), 32, 1'b0, 0, m);
         exp_a[ch] = 32'hA5A5_0000 | 32'(ch);
         n_checks++; if (m !== tx) begin n_errors++; $display("FAIL sweep_miso ch%0d: got %h want %h", ch, m, tx); end
         n_checks++; if (a_vcnt - v0 !== 1 || a_vlast !== (4'b1 << ch)) begin
            n_errors++; $display("FAIL sweep_valid ch%0d: pulses=%0d last=%b", ch, a_vcnt - v0, a_vlast); end
         n_checks++; if (a_odata !== exp_a_vec()) begin n_errors++; $display("FAIL sweep_data ch%0d: got %h want %h", ch, a_odata, exp_a_vec()); end
      end
   endtask

   task automatic test_random();
      logic [31:0] m, tx, rx;
      for (int it = 0; it < 6; it++) begin
         int ch  = $urandom_range(0, 3);
         bit rl  = 1'($urandom_range(0, 1));
         int v0  = a_vcnt;
         tx = $urandom(); rx = $urandom();
         a_frame(ch, tx, rx, 32, rl, 0, m);
         exp_a[ch] = rx;
         n_checks++; if (m !== tx) begin n_errors++; $display("FAIL random_miso it%0d: got %h want %h", it, m, tx); end
         n_checks++; if (a_vcnt - v0 !== 1 || a_vlast !== (4'b1 << ch) || a_vdata !== exp_a_vec()) begin
            n_errors++; $display("FAIL random_frame it%0d ch%0d rel_last=%0d: pulses=%0d last=%b data=%h want %h",
                                 it, ch, rl, a_vcnt - v0, a_vlast, a_vdata, exp_a_vec()); end
      end
   endtask

   task automatic test_abort();
      logic [31:0] m, tx;
      int v0 = a_vcnt;
      tx = $urandom();
      a_frame(2, tx, 32'hFFFFFFFF, 17, 1'b0, 0, m);
      n_checks++; if ((m & 32'hFFFF8000) !== (tx & 32'hFFFF8000)) begin
         n_errors++; $display("FAIL abort_miso: got %h want %h", m & 32'hFFFF8000, tx & 32'hFFFF8000); end
      n_checks++; if (a_vcnt - v0 !== 0) begin n_errors++; $display("FAIL abort_valid: pulses=%0d want 0", a_vcnt - v0); end
      n_checks++; if (a_odata !== exp_a_vec()) begin n_errors++; $display("FAIL abort_data: got %h want %h", a_odata, exp_a_vec()); end
      v0 = a_vcnt;
      a_frame(2, tx, 32'h0000_00FF, 32, 1'b0, 0, m);
      exp_a[2] = 32'h0000_00FF;
      n_checks++; if (a_vcnt - v0 !== 1 || a_odata !== exp_a_vec() || m !== tx) begin
         n_errors++; $display("FAIL abort_next_frame: pulses=%0d data=%h want %h miso=%h want %h", a_vcnt - v0, a_odata, exp_a_vec(), m, tx); end
   endtask

   task automatic test_collision();
      logic [31:0] m, tx;
      int v0 = a_vcnt;
      a_data[31:0] = 32'hFFFFFFFF;
      a_cs[0] = 1'b0;
      repeat (8) @(negedge clk);
      a_bits($urandom(), 10, 1'b0, 0, m);
      a_cs[3] = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (a_err !== 1'b1) begin n_errors++; $display("FAIL coll_err: got %b want 1", a_err); end
      n_checks++; if (a_miso !== 1'b0) begin n_errors++; $display("FAIL coll_miso: got %b want 0", a_miso); end
      a_bits($urandom(), 8, 1'b0, 0, m);
      n_checks++; if (m !== '0) begin n_errors++; $display("FAIL coll_miso_stream: got %h want 0", m); end
      a_cs[0] = 1'b1; a_cs[3] = 1'b1;
      repeat (8) @(negedge clk);
      n_checks++; if (a_vcnt - v0 !== 0 || a_odata !== exp_a_vec() || a_err !== 1'b1) begin
         n_errors++; $display("FAIL coll_after: pulses=%0d data=%h want %h err=%b", a_vcnt - v0, a_odata, exp_a_vec(), a_err); end
      tx = $urandom();
      a_frame(1, tx, 32'h0BADF00D, 32, 1'b0, 0, m);
      exp_a[1] = 32'h0BADF00D;
      n_checks++; if (a_vcnt - v0 !== 1 || a_odata !== exp_a_vec() || a_err !== 1'b1 || m !== tx) begin
         n_errors++; $display("FAIL coll_clean_frame: pulses=%0d data=%h want %h err=%b miso=%h want %h",
                              a_vcnt - v0, a_odata, exp_a_vec(), a_err, m, tx); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] m, tx;
      int v0;
      a_data[63:32] = $urandom();
      a_cs[1] = 1'b0;
      repeat (8) @(negedge clk);
      a_bits($urandom(), 10, 1'b0, 1, m);
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (a_odata !== '0 || a_valid !== '0 || a_miso !== 1'b0 || a_err !== 1'b0) begin
         n_errors++; $display("FAIL rstmid_outputs: data=%h valid=%b miso=%b err=%b, want all 0", a_odata, a_valid, a_miso, a_err); end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) exp_a[k] = '0;
      for (int k = 0; k < 2; k++) exp_b[k] = '0;
      v0 = a_vcnt;
      a_bits($urandom(), 8, 1'b0, 1, m);
      n_checks++; if (a_vcnt - v0 !== 0 || m[31:24] !== 8'h00) begin
         n_errors++; $display("FAIL rstmid_ignored: pulses=%0d miso=%h want 0 pulses 00", a_vcnt - v0, m[31:24]); end
      a_cs[1] = 1'b1;
      repeat (8) @(negedge clk);
      tx = $urandom();
      a_frame(1, tx, 32'hC0FFEE11, 32, 1'b0, 0, m);
      exp_a[1] = 32'hC0FFEE11;
      n_checks++; if (a_vcnt - v0 !== 1 || a_odata !== exp_a_vec() || m !== tx) begin
         n_errors++; $display("FAIL rstmid_next_frame: pulses=%0d data=%h want %h miso=%h want %h", a_vcnt - v0, a_odata, exp_a_vec(), m, tx); end
   endtask

   task automatic test_lsb_first();
      logic [7:0] m, tx, rx;
      int v0 = b_vcnt;
      tx = 8'($urandom());
      b_frame(1, tx, 8'h81, m);
      exp_b[1] = 8'h81;
      n_checks++; if (m !== tx) begin n_errors++; $display("FAIL lsb_miso: got %h want %h", m, tx); end
      n_checks++; if (b_vcnt - v0 !== 1 || b_vlast !== 2'b10 || b_vdata !== {exp_b[1], exp_b[0]}) begin
         n_errors++; $display("FAIL lsb_frame: pulses=%0d last=%b data=%h want %h", b_vcnt - v0, b_vlast, b_vdata, {exp_b[1], exp_b[0]}); end
      v0 = b_vcnt;
      tx = 8'($urandom()); rx = 8'($urandom());
      b_frame(0, tx, rx, m);
      exp_b[0] = rx;
      n_checks++; if (m !== tx || b_vcnt - v0 !== 1 || b_vlast !== 2'b01 || b_odata !== {exp_b[1], exp_b[0]}) begin
         n_errors++; $display("FAIL lsb_ch0: miso=%h want %h pulses=%0d last=%b data=%h want %h",
                              m, tx, b_vcnt - v0, b_vlast, b_odata, {exp_b[1], exp_b[0]}); end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      a_sclk = 1'b0; a_mosi = 1'b0; a_cs = '1; a_data = '0;
      b_sclk = 1'b0; b_mosi = 1'b0; b_cs = '1; b_data = '0;
      test_reset();
      test_single();
      test_sweep();
      test_random();
      test_abort();
      test_collision();
      test_reset_mid_frame();
      test_lsb_first();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
